// File: rtl/instruction_fetcher_pkg.sv
// Types and helpers shared by the instruction fetcher and its queue.
`include "const_def.v"

package instruction_fetcher_pkg;

    localparam logic [6:0] OPCODE_JAL = `OPCODE_JAL;

    typedef enum logic {
        FETCH_WAIT  = 1'b0,
        FETCH_READY = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        compressed;
        logic        taken;
        logic [31:0] pred_pc;
    } iq_entry_t;

    // Only inst[31:12] carries the J-immediate; bit positions are kept as in the instruction word.
    function automatic logic [31:0] jal_offset(input logic [31:12] hi);
        return {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/const_def.v
// Shared fetch-path constants: default queue depth and the JAL major opcode.
`ifndef CONST_DEF_V
`define CONST_DEF_V
`define IQ_SIZE_LOG 2
`define OPCODE_JAL 7'b1101111
`endif

// File: rtl/instruction_fetcher_queue.sv
// fetch_queue: circular instruction queue, registered pointers, combinational head.
// Push ignored when full (even alongside a pop); clear and reset empty it in one cycle.
module fetch_queue
    import instruction_fetcher_pkg::*;
#(
    parameter int SIZE_LOG = 2
) (
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  iq_entry_t push_dat,
    output logic      full,
    output logic      empty,
    output iq_entry_t head_dat
);

    localparam int unsigned         DEPTH    = 2 ** SIZE_LOG;
    localparam logic [SIZE_LOG-1:0] PTR_ONE  = SIZE_LOG'(1);
    localparam logic [SIZE_LOG:0]   CNT_ONE  = (SIZE_LOG + 1)'(1);
    localparam logic [SIZE_LOG:0]   CNT_FULL = (SIZE_LOG + 1)'(DEPTH);

    iq_entry_t           r_mem [DEPTH];
    logic [SIZE_LOG-1:0] r_wr_ptr;
    logic [SIZE_LOG-1:0] r_rd_ptr;
    logic [SIZE_LOG:0]   r_count;
    logic                w_push;
    logic                w_pop;

    assign full     = (r_count == CNT_FULL);
    assign empty    = (r_count == '0);
    assign w_push   = push && !full && !clear && !rst_in;
    assign w_pop    = pop && !empty && !clear && !rst_in;
    assign head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch unit: drives ic_pc, waits for the cache to settle, predicts JAL targets, queues entries.
// Latency: SETTLE_CYCLES+1 cycles per fetched instruction; stalls while the queue is full; flush redirects.
`include "const_def.v"

module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int IQ_SIZE_LOG   = `IQ_SIZE_LOG,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    output logic [31:0] ic_pc,
    input  logic [31:0] ic_inst,
    input  logic        ic_valid,
    input  logic        ic_compressed,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_compressed,
    output logic        dec_pred_taken,
    output logic [31:0] dec_pred_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    input  logic        flush_in,
    input  logic [31:0] flush_pc
);

    localparam int            CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_ONE  = CW'(1);

    logic [31:0]  r_pc;
    logic [CW-1:0] r_settle;

    fetch_state_e w_state;
    logic         w_is_jal;
    logic [31:0]  w_next_pc;
    logic         w_accept;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    iq_entry_t    w_push_dat;
    iq_entry_t    w_head;

    assign ic_pc     = r_pc;
    assign w_state   = (r_settle == '0) ? FETCH_READY : FETCH_WAIT;
    assign w_is_jal  = (ic_inst[6:0] == OPCODE_JAL);
    assign w_next_pc = w_is_jal      ? r_pc + jal_offset(ic_inst[31:12])
                     : ic_compressed ? r_pc + 32'd2
                     :                 r_pc + 32'd4;

    // Flush outranks both sides of the queue in the same cycle.
    assign w_accept = (w_state == FETCH_READY) && ic_valid && !w_full && !flush_in;
    assign w_pop    = !w_empty && dec_ready && !flush_in;

    assign w_push_dat = '{
        inst:       ic_inst,
        pc:         r_pc,
        compressed: ic_compressed,
        taken:      w_is_jal,
        pred_pc:    w_next_pc
    };

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc     <= '0;
            r_settle <= SETTLE_LOAD;
        end else if (flush_in) begin
            r_pc     <= flush_pc;
            r_settle <= SETTLE_LOAD;
        end else if (w_accept) begin
            r_pc     <= w_next_pc;
            r_settle <= SETTLE_LOAD;
        end else if (r_settle != '0) begin
            r_settle <= r_settle - SETTLE_ONE;
        end
    end

    fetch_queue #(
        .SIZE_LOG (IQ_SIZE_LOG)
    ) u_fetch_queue (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (w_accept),
        .pop      (w_pop),
        .clear    (flush_in),
        .push_dat (w_push_dat),
        .full     (w_full),
        .empty    (w_empty),
        .head_dat (w_head)
    );

    assign dec_valid      = !w_empty;
    assign dec_inst       = w_head.inst;
    assign dec_pc         = w_head.pc;
    assign dec_compressed = w_head.compressed;
    assign dec_pred_taken = w_head.taken;
    assign dec_pred_pc    = w_head.pred_pc;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed scenarios plus a randomized run against a queue-based model.
module tb_instruction_fetcher;

    localparam int          S     = 2;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] ic_pc;
    logic [31:0] ic_inst = NOP;
    logic        ic_valid = 1'b0;
    logic        ic_compressed = 1'b0;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_compressed;
    logic        dec_pred_taken;
    logic [31:0] dec_pred_pc;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic        flush_in = 1'b0;
    logic [31:0] flush_pc = '0;

    always #5 clk_in = ~clk_in;

    instruction_fetcher #(.IQ_SIZE_LOG(2), .SETTLE_CYCLES(S)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .ic_pc          (ic_pc),
        .ic_inst        (ic_inst),
        .ic_valid       (ic_valid),
        .ic_compressed  (ic_compressed),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc),
        .dec_compressed (dec_compressed),
        .dec_pred_taken (dec_pred_taken),
        .dec_pred_pc    (dec_pred_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .flush_in       (flush_in),
        .flush_pc       (flush_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // What the bench knows about the instruction it is presenting (no decoding needed).
    logic cur_jal = 1'b0;
    int   cur_off = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        cmp;
        logic        taken;
        logic [31:0] pred;
    } m_entry_t;

    m_entry_t    mq[$];
    logic [31:0] m_pc = '0;
    int          m_since = 0;

    function automatic logic [31:0] enc_jal(input int off, input logic [4:0] rd);
        logic [20:0] o;
        o = off[20:0];
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
    endfunction

    // Advance one clock: update the model from the inputs about to be sampled, then step the DUT.
    task automatic tick();
        bit          acc;
        bit          pop;
        logic [31:0] nxt;
        m_entry_t    e;
        nxt = cur_jal ? m_pc + 32'(cur_off) : m_pc + (ic_compressed ? 32'd2 : 32'd4);
        if (rst_in) begin
            m_pc = '0; m_since = 0; mq.delete();
        end else if (flush_in) begin
            mq.delete(); m_pc = flush_pc; m_since = 0;
        end else begin
            acc = (m_since >= S) && ic_valid && (mq.size() < DEPTH);
            pop = (mq.size() > 0) && dec_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                e = '{ic_inst, m_pc, ic_compressed, cur_jal, nxt};
                mq.push_back(e);
                m_pc = nxt;
                m_since = 0;
            end else if (m_since < 1000) begin
                m_since++;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    // Redirect to pc, then present one instruction until it lands in the queue.
    task automatic redirect_fetch_one(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic cmp, input logic jal, input int off,
                                      output int waited);
        flush_in = 1'b1; flush_pc = pc; ic_valid = 1'b0; dec_ready = 1'b0;
        tick();
        flush_in = 1'b0;
        ic_inst = inst; ic_compressed = cmp; cur_jal = jal; cur_off = off; ic_valid = 1'b1;
        waited = 0;
        while (!dec_valid && waited < 10) begin
            tick();
            waited++;
        end
        ic_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; ic_valid = 1'b1; dec_ready = 1'b0; flush_in = 1'b0;
        tick(); tick();
        n_tests++;
        if (ic_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", ic_pc); end
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got %b want 0", dec_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] seen[$];
        int          first_change;
        rst_in = 1'b1; ic_valid = 1'b1; ic_inst = NOP; ic_compressed = 1'b0; cur_jal = 1'b0; dec_ready = 1'b0;
        tick();
        rst_in = 1'b0;
        seen.push_back(ic_pc);
        first_change = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ic_pc !== seen[$]) begin
                seen.push_back(ic_pc);
                if (first_change < 0) first_change = i;
            end
        end
        n_tests++;
        if (first_change != S + 1) begin n_fail++; $display("FAIL fill_first_accept got tick %0d want %0d", first_change, S + 1); end
        n_tests++;
        if (seen.size() != 5) begin n_fail++; $display("FAIL fill_pc_steps got %0d distinct pcs want 5", seen.size()); end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            n_tests++;
            if (seen[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL fill_pc_seq[%0d] got %h want %h", i, seen[i], 32'(4 * i)); end
        end
        n_tests++;
        if (ic_pc !== 32'd16) begin n_fail++; $display("FAIL fill_hold_pc got %h want 00000010", ic_pc); end
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin
            n_fail++; $display("FAIL fill_head got valid=%b pc=%h want valid=1 pc=00000000", dec_valid, dec_pc);
        end
    endtask

    task automatic test_full_pop();
        ic_valid = 1'b1; dec_ready = 1'b1;
        tick();
        n_tests++;
        if (dec_pc !== 32'd4 || ic_pc !== 32'd16) begin
            n_fail++; $display("FAIL full_pop_no_push got head=%h pc=%h want head=00000004 pc=00000010", dec_pc, ic_pc);
        end
        dec_ready = 1'b0;
        tick();
        n_tests++;
        if (ic_pc !== 32'd20) begin n_fail++; $display("FAIL full_pop_next_push got pc=%h want 00000014", ic_pc); end
        ic_valid = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (i + 1))) begin
                n_fail++; $display("FAIL full_pop_drain[%0d] got valid=%b pc=%h want valid=1 pc=%h", i, dec_valid, dec_pc, 32'(4 * (i + 1)));
            end
            tick();
        end
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty got valid=%b want 0", dec_valid); end
        dec_ready = 1'b0;
    endtask

    task automatic test_compressed();
        int waited;
        redirect_fetch_one(32'h100, NOP, 1'b1, 1'b0, 0, waited);
        n_tests++;
        if (waited != S + 1) begin n_fail++; $display("FAIL cmp_settle got %0d ticks want %0d", waited, S + 1); end
        n_tests++;
        if (dec_pc !== 32'h100 || dec_pred_pc !== 32'h102 || dec_compressed !== 1'b1 || dec_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL cmp_entry got pc=%h pred=%h c=%b t=%b want 00000100 00000102 1 0",
                               dec_pc, dec_pred_pc, dec_compressed, dec_pred_taken);
        end
        n_tests++;
        if (ic_pc !== 32'h102) begin n_fail++; $display("FAIL cmp_next_pc got %h want 00000102", ic_pc); end
    endtask

    task automatic test_jal();
        int          waited;
        logic [31:0] inst;
        inst = enc_jal(-8, 5'd1);
        redirect_fetch_one(32'h20, inst, 1'b0, 1'b1, -8, waited);
        n_tests++;
        if (waited > 9 || dec_pred_taken !== 1'b1 || dec_pred_pc !== 32'h18 || dec_inst !== inst) begin
            n_fail++; $display("FAIL jal_entry got t=%b pred=%h inst=%h want 1 00000018 %h", dec_pred_taken, dec_pred_pc, dec_inst, inst);
        end
        n_tests++;
        if (ic_pc !== 32'h18) begin n_fail++; $display("FAIL jal_next_pc got %h want 00000018", ic_pc); end
    endtask

    task automatic test_wrap();
        int waited;
        redirect_fetch_one(32'hFFFF_FFFC, NOP, 1'b0, 1'b0, 0, waited);
        n_tests++;
        if (waited > 9 || dec_pc !== 32'hFFFF_FFFC || dec_pred_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_entry got pc=%h pred=%h want fffffffc 00000000", dec_pc, dec_pred_pc);
        end
        n_tests++;
        if (ic_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc got %h want 00000000", ic_pc); end
    endtask

    task automatic test_flush();
        int n;
        flush_in = 1'b1; flush_pc = 32'h0; ic_valid = 1'b0; dec_ready = 1'b0;
        tick();
        flush_in = 1'b0; ic_valid = 1'b1; ic_inst = NOP; ic_compressed = 1'b0; cur_jal = 1'b0;
        n = 0;
        while (ic_pc !== 32'd12 && n < 30) begin tick(); n++; end
        n_tests++;
        if (ic_pc !== 32'd12) begin n_fail++; $display("FAIL flush_prefill timeout pc=%h want 0000000c", ic_pc); end
        tick(); tick();
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'd0) begin
            n_fail++; $display("FAIL flush_pre_head got valid=%b pc=%h want 1 00000000", dec_valid, dec_pc);
        end
        flush_in = 1'b1; flush_pc = 32'h400; dec_ready = 1'b1;
        tick();
        flush_in = 1'b0; dec_ready = 1'b0;
        n_tests++;
        if (dec_valid !== 1'b0 || ic_pc !== 32'h400) begin
            n_fail++; $display("FAIL flush_redirect got valid=%b pc=%h want 0 00000400", dec_valid, ic_pc);
        end
        for (int i = 0; i < S; i++) begin
            tick();
            n_tests++;
            if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_settle[%0d] got valid=%b want 0", i, dec_valid); end
        end
        tick();
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h400 || ic_pc !== 32'h404) begin
            n_fail++; $display("FAIL flush_first_fetch got valid=%b head=%h pc=%h want 1 00000400 00000404", dec_valid, dec_pc, ic_pc);
        end
    endtask

    task automatic test_reset_mid();
        tick(); tick();
        rst_in = 1'b1; ic_valid = 1'b1; dec_ready = 1'b1;
        tick();
        rst_in = 1'b0; ic_valid = 1'b0; dec_ready = 1'b0;
        n_tests++;
        if (dec_valid !== 1'b0 || ic_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid got valid=%b pc=%h want 0 00000000", dec_valid, ic_pc);
        end
        tick(); tick(); tick();
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_enqueue got valid=%b want 0", dec_valid); end
    endtask

    task automatic test_random();
        int r;
        rst_in = 1'b1; flush_in = 1'b0;
        tick();
        rst_in = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            ic_valid  = ($urandom_range(0, 9) < 7);
            dec_ready = ($urandom_range(0, 1) == 1);
            flush_in  = ($urandom_range(0, 29) == 0);
            rst_in    = ($urandom_range(0, 99) == 0);
            flush_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            ic_compressed = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 2097151)) & ~1;
                if (r >= 1048576) r -= 2097152;
                cur_jal = 1'b1; cur_off = r;
                ic_inst = enc_jal(r, 5'($urandom_range(0, 31)));
            end else begin
                cur_jal = 1'b0; cur_off = 0;
                ic_inst = $urandom;
                if (ic_inst[6:0] == 7'b1101111) ic_inst[0] = 1'b0;
            end
            tick();
            n_tests++;
            if (ic_pc !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", cyc, ic_pc, m_pc); end
            n_tests++;
            if (dec_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, dec_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_tests++;
                if (dec_inst !== mq[0].inst || dec_pc !== mq[0].pc || dec_compressed !== mq[0].cmp ||
                    dec_pred_taken !== mq[0].taken || dec_pred_pc !== mq[0].pred) begin
                    n_fail++;
                    $display("FAIL rand_head cyc %0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h", cyc,
                             dec_inst, dec_pc, dec_compressed, dec_pred_taken, dec_pred_pc,
                             mq[0].inst, mq[0].pc, mq[0].cmp, mq[0].taken, mq[0].pred);
                end
            end
        end
        rst_in = 1'b0; flush_in = 1'b0; ic_valid = 1'b0; dec_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_compressed();
        test_jal();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 Parameter IQ_SIZE_LOG, default 2: instruction queue depth is 2^IQ_SIZE_LOG entries.
REQ-002 Parameter SETTLE_CYCLES, default 2: cycles after an ic_pc change before ic_valid and ic_inst are trusted.
REQ-003 clk_in  input  1  sole clock; all state updates on posedge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 ic_pc  output  32  fetch address to the instruction cache; combinational copy of the pc register.
REQ-006 ic_inst  input  32  instruction from the cache, already decompressed to 32 bits.
REQ-007 ic_valid  input  1  cache hit for the current ic_pc.
REQ-008 ic_compressed  input  1  the original instruction was 16-bit.
REQ-009 dec_inst  output  32  head-entry instruction to the decoder.
REQ-010 dec_pc  output  32  head-entry pc.
REQ-011 dec_compressed  output  1  head-entry compressed flag.
REQ-012 dec_pred_taken  output  1  head entry was predicted taken.
REQ-013 dec_pred_pc  output  32  head-entry predicted next pc.
REQ-014 dec_valid  output  1  queue non-empty.
REQ-015 dec_ready  input  1  decoder accepts the head this cycle.
REQ-016 flush_in  input  1  redirect request (mispredict or exception).
REQ-017 flush_pc  input  32  redirect target.

Function
REQ-018 A settle counter shall be reloaded with SETTLE_CYCLES on every pc change and decremented to 0; state is WAIT when counter>0 and READY when counter==0.
REQ-019 Accept shall occur in a cycle iff READY, ic_valid=1, queue not full and flush_in=0.
REQ-020 On accept, the enqueued entry shall be {ic_inst, pc, ic_compressed, taken, next}, and pc shall be set to next.
REQ-021 If ic_inst[6:0]==1101111 (JAL), next = pc + sign-extended J-immediate and taken=1; otherwise next = pc + (ic_compressed ? 2 : 4) and taken=0.
REQ-022 All pc arithmetic is modulo 2^32 and wraps silently.
REQ-023 dec_* outputs shall be driven combinationally from the queue head; while empty, dec_valid=0 and the other dec_* outputs are don't-care.
REQ-024 A pop occurs when dec_valid && dec_ready.
REQ-025 Push is blocked when the queue is full, even if a pop occurs in the same cycle.
REQ-026 A simultaneous push and pop on a non-full, non-empty queue shall leave the count unchanged.
REQ-027 Read and write pointers wrap modulo the queue depth; the count is IQ_SIZE_LOG+1 bits wide.
REQ-028 flush_in has highest priority: the queue empties, pc <= flush_pc, the settle counter reloads, and any accept or pop in that cycle is suppressed.
REQ-029 The earliest accept after a pc change shall be SETTLE_CYCLES cycles later.

Reset
REQ-030 While rst_in=1 at posedge: pc=0, queue empty, dec_valid=0, settle counter=SETTLE_CYCLES.
REQ-031 Reset mid-operation shall discard all queued entries and any in-progress fetch, with no partial enqueue.

Structure
REQ-032 `IQ_SIZE_LOG and `OPCODE_JAL shall be defined in const_def.v, included by this block.
REQ-033 The FIFO shall be a sub-module named fetch_queue (push, pop, clear, full, empty, head data); pc, next-pc and settle logic stay in instruction_fetcher.

Verification
REQ-034 Reset, then ic_valid=1 with 4-byte NOPs and dec_ready=0 -> ic_pc steps 0,4,8,12; queue fills 4 entries; ic_pc holds at 16 once full.
REQ-035 ic_compressed=1 at pc 0x100 -> enqueued pred_pc=0x102 and next ic_pc=0x102.
REQ-036 JAL imm=-8 at pc 0x20 -> pred_taken=1, pred_pc=0x18, ic_pc=0x18 the next cycle.
REQ-037 Queue full with dec_ready=1 and ic_valid=1 in the same cycle -> one pop, no push, count 4->3; push occurs the following cycle.
REQ-038 flush_in=1 with flush_pc=0x400 while 3 entries are queued and an accept is possible -> dec_valid=0 next cycle, ic_pc=0x400, no enqueue until SETTLE_CYCLES elapse.
REQ-039 pc=0xFFFFFFFC with a 4-byte non-JAL instruction -> pred_pc=0x00000000.
